// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizes for the Wishbone-to-async-SRAM controller.
package sram_ctrl_pkg;
   localparam int SRAM_AW = 18;
   localparam int SRAM_DW = 16;

   typedef enum logic [2:0] {IDLE, RD, WSETUP, WR, ACK} state_t;

   typedef struct packed {
      logic [SRAM_AW-1:0] adr;
      logic [SRAM_DW-1:0] dat;
      logic [1:0]         sel;
      logic               we;
   } wb_req_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a one-hot grant; lock pins the grant to the previous winner.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   input  logic       lock,
   output logic [1:0] gnt,
   output logic       last_grant
);
   always_comb begin
      gnt = 2'b00;
      if (lock) begin
         gnt[last_grant] = req[last_grant];
      end else if (req == 2'b11) begin
         gnt[~last_grant] = 1'b1;
      end else begin
         gnt = req;
      end
   end

   // Reset to master 1 so master 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (advance && (gnt != 2'b00)) begin
         last_grant <= gnt[1];
      end
   end
endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave sharing one async 256Kx16 SRAM between two masters.
// Define SRAM_CYC_LOCK_EN to let a master that keeps cyc_i high retain the grant across transactions.
module wb_sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int AW      = SRAM_AW,
   parameter int DW      = SRAM_DW,
   parameter int RD_WAIT = 1,
   parameter int WR_WAIT = 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   input  logic          m0_we_i,
   input  logic [1:0]    m0_sel_i,
   input  logic [AW-1:0] m0_adr_i,
   input  logic [DW-1:0] m0_dat_i,
   output logic [DW-1:0] m0_dat_o,
   output logic          m0_ack_o,
   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   input  logic          m1_we_i,
   input  logic [1:0]    m1_sel_i,
   input  logic [AW-1:0] m1_adr_i,
   input  logic [DW-1:0] m1_dat_i,
   output logic [DW-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic [AW-1:0] sram_a_o,
   output logic [DW-1:0] sram_d_o,
   output logic          sram_d_oe_o,
   input  logic [DW-1:0] sram_d_i,
   output logic          sram_ce_n_o,
   output logic          sram_oe_n_o,
   output logic          sram_we_n_o,
   output logic          sram_lb_n_o,
   output logic          sram_ub_n_o,
   output state_t        state_o
);
   localparam logic [2:0] RD_CNT = 3'(RD_WAIT);
   localparam logic [2:0] WR_CNT = 3'(WR_WAIT);

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   wb_req_t    req_q, new_req;
   logic [1:0] req, gnt, ack_d, sel_d;
   logic       advance, lock, last_grant;
   logic       ce_d, oe_d, we_d, lb_d, ub_d, doe_d;

   // Handshake: a master requests with cyc&stb high and holds them until it sees a one-cycle ack.
   assign req      = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
   assign state_o  = state_q;
   assign sram_a_o = req_q.adr;
   assign sram_d_o = req_q.dat;

   always_comb begin
      if (gnt[1]) new_req = '{adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i, we: m1_we_i};
      else        new_req = '{adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i, we: m0_we_i};
   end

   rr_arb2 u_arb (
      .clk        (clk_i),
      .rst        (rst_i),
      .req        (req),
      .advance    (advance),
      .lock       (lock),
      .gnt        (gnt),
      .last_grant (last_grant)
   );

`ifdef SRAM_CYC_LOCK_EN
   logic       held_q;
   logic [1:0] cyc;
   assign cyc  = {m1_cyc_i, m0_cyc_i};
   assign lock = held_q & cyc[last_grant];
   // Ownership lapses as soon as the previous winner lets cyc_i fall.
   always_ff @(posedge clk_i) begin
      if (rst_i)                  held_q <= 1'b0;
      else if (advance)           held_q <= 1'b1;
      else if (!cyc[last_grant])  held_q <= 1'b0;
   end
`else
   assign lock = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      advance = 1'b0;
      ce_d    = 1'b1;
      oe_d    = 1'b1;
      we_d    = 1'b1;
      lb_d    = 1'b1;
      ub_d    = 1'b1;
      doe_d   = 1'b0;
      ack_d   = 2'b00;
      sel_d   = (state_q == IDLE) ? new_req.sel : req_q.sel;
      case (state_q)
         IDLE: if (gnt != 2'b00) begin
            advance = 1'b1;
            state_d = new_req.we ? WSETUP : RD;
            cnt_d   = new_req.we ? WR_CNT : RD_CNT;
         end
         RD:      if (cnt_q == 3'd0) state_d = ACK; else cnt_d = cnt_q - 3'd1;
         WSETUP:  state_d = WR;
         WR:      if (cnt_q == 3'd0) state_d = ACK; else cnt_d = cnt_q - 3'd1;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Strobes are computed for the state being entered so they register in step with it.
      case (state_d)
         RD: begin
            ce_d = 1'b0; oe_d = 1'b0; lb_d = ~sel_d[0]; ub_d = ~sel_d[1];
         end
         WSETUP: begin
            ce_d = 1'b0; doe_d = 1'b1; lb_d = ~sel_d[0]; ub_d = ~sel_d[1];
         end
         WR: begin
            ce_d = 1'b0; doe_d = 1'b1; we_d = 1'b0; lb_d = ~sel_d[0]; ub_d = ~sel_d[1];
         end
         ACK: begin
            doe_d             = req_q.we;
            ack_d[last_grant] = req[last_grant];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         req_q       <= '0;
         sram_d_oe_o <= 1'b0;
         sram_ce_n_o <= 1'b1;
         sram_oe_n_o <= 1'b1;
         sram_we_n_o <= 1'b1;
         sram_lb_n_o <= 1'b1;
         sram_ub_n_o <= 1'b1;
         m0_ack_o    <= 1'b0;
         m1_ack_o    <= 1'b0;
         m0_dat_o    <= '0;
         m1_dat_o    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sram_d_oe_o <= doe_d;
         sram_ce_n_o <= ce_d;
         sram_oe_n_o <= oe_d;
         sram_we_n_o <= we_d;
         sram_lb_n_o <= lb_d;
         sram_ub_n_o <= ub_d;
         m0_ack_o    <= ack_d[0];
         m1_ack_o    <= ack_d[1];
         if (advance) req_q <= new_req;
         if (state_q == RD && cnt_q == 3'd0) begin
            if (last_grant) m1_dat_o <= sram_d_i;
            else            m0_dat_o <= sram_d_i;
         end
      end
   end
endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Self-checking bench for wb_sram_ctrl: vector table, concurrent masters, reset and abort corners.
// Lock-dependent expectations follow SRAM_CYC_LOCK_EN.
module tb_wb_sram_ctrl;
   import sram_ctrl_pkg::*;

   typedef struct {
      int          we_lo;
      int          oe_lo;
      logic        lb_n;
      logic        ub_n;
      logic [17:0] a;
      logic [15:0] d;
   } obs_t;

   typedef struct {
      logic        we;
      logic [17:0] adr;
      logic [15:0] dat;
      logic [1:0]  sel;
      int          lat;
      logic        lb_n;
      logic        ub_n;
      logic [15:0] rd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc [2];
   logic        stb [2];
   logic        we  [2];
   logic [1:0]  sel [2];
   logic [17:0] adr [2];
   logic [15:0] wdat[2];
   logic [15:0] rdat[2];
   logic        ack [2];
   logic [17:0] sram_a;
   logic [15:0] sram_d, sram_rd;
   logic        sram_doe, ce_n, oe_n, we_n, lb_n, ub_n;
   state_t      dut_state;

   int          tests = 0;
   int          fails = 0;
   logic [17:0] exp_q[$];   // {master, we, read data}
   logic [15:0] mem [logic [17:0]];

   always #5 clk = ~clk;

   wb_sram_ctrl #(.AW(18), .DW(16), .RD_WAIT(1), .WR_WAIT(1)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
      .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(rdat[0]), .m0_ack_o(ack[0]),
      .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
      .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(rdat[1]), .m1_ack_o(ack[1]),
      .sram_a_o(sram_a), .sram_d_o(sram_d), .sram_d_oe_o(sram_doe), .sram_d_i(sram_rd),
      .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n),
      .sram_lb_n_o(lb_n), .sram_ub_n_o(ub_n), .state_o(dut_state)
   );

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void expect_ack(input int m, input logic w, input logic [15:0] d);
      exp_q.push_back({(m == 1), w, d});
   endfunction

   // Async SRAM model; bytes written without the bus driven land as a poison value.
   always @(negedge clk) begin
      logic [15:0] w;
      if (!ce_n && !we_n) begin
         w = mem.exists(sram_a) ? mem[sram_a] : 16'h0000;
         if (!lb_n) w[7:0]  = sram_doe ? sram_d[7:0]  : 8'hDE;
         if (!ub_n) w[15:8] = sram_doe ? sram_d[15:8] : 8'hAD;
         mem[sram_a] = w;
      end
      if (!ce_n && !oe_n) sram_rd = mem.exists(sram_a) ? mem[sram_a] : 16'h0000;
      else                sram_rd = 16'h0000;
   end

   // Scoreboard: every ack must match the oldest expected transaction.
   always @(negedge clk) begin
      logic [17:0] e;
      if (ack[0] === 1'b1 || ack[1] === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'({ack[1], ack[0]}), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("ack_master", 32'({ack[1], ack[0]}), e[17] ? 32'd2 : 32'd1);
            if (!e[16]) check("rd_data", 32'(rdat[e[17]]), 32'(e[15:0]));
         end
      end
   end

   task automatic wait_ack(input int m, output int lat, output obs_t o);
      int n;
      n = 0;
      o.we_lo = 0; o.oe_lo = 0; o.lb_n = 1'b0; o.ub_n = 1'b0; o.a = '0; o.d = '0;
      do begin
         @(negedge clk);
         if (!we_n) begin o.we_lo++; o.lb_n = lb_n; o.ub_n = ub_n; o.a = sram_a; o.d = sram_d; end
         if (!oe_n) begin o.oe_lo++; o.lb_n = lb_n; o.ub_n = ub_n; o.a = sram_a; end
         n++;
      end while (ack[m] !== 1'b1 && n < 40);
      lat = n - 1;
      check($sformatf("ack_seen_m%0d", m), 32'(ack[m]), 32'd1);
   endtask

   task automatic xfer(input int m, input logic w, input logic [17:0] a, input logic [15:0] d,
                       input logic [1:0] s, input bit keep, output int lat, output obs_t o);
      we[m] = w; adr[m] = a; wdat[m] = d; sel[m] = s; cyc[m] = 1'b1; stb[m] = 1'b1;
      wait_ack(m, lat, o);
      @(posedge clk); #1;
      if (!keep) begin cyc[m] = 1'b0; stb[m] = 1'b0; end
   endtask

   task automatic run_reads(input int m, input logic [17:0] base, input int n, input bit keep, input bit gap);
      int   lat;
      obs_t o;
      for (int i = 0; i < n; i++) begin
         xfer(m, 1'b0, base + 18'(i), 16'h0000, 2'b11, keep && (i < n - 1), lat, o);
         if (gap && i < n - 1) begin @(posedge clk); #1; end
      end
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[9];
      int   lat, n;
      obs_t o;
      bit   gap;

      for (int m = 0; m < 2; m++) begin
         cyc[m] = 1'b0; stb[m] = 1'b0; we[m] = 1'b0; sel[m] = 2'b00; adr[m] = '0; wdat[m] = '0;
      end
      vt[0] = '{1'b1, 18'h12345, 16'hBEEF, 2'b11, 4, 1'b0, 1'b0, 16'h0000};
      vt[1] = '{1'b0, 18'h12345, 16'h0000, 2'b11, 3, 1'b0, 1'b0, 16'hBEEF};
      vt[2] = '{1'b1, 18'h12345, 16'h00AA, 2'b01, 4, 1'b0, 1'b1, 16'h0000};
      vt[3] = '{1'b0, 18'h12345, 16'h0000, 2'b11, 3, 1'b0, 1'b0, 16'hBEAA};
      vt[4] = '{1'b1, 18'h00010, 16'hA5C3, 2'b10, 4, 1'b1, 1'b0, 16'h0000};
      vt[5] = '{1'b0, 18'h00010, 16'h0000, 2'b11, 3, 1'b0, 1'b0, 16'hA500};
      vt[6] = '{1'b1, 18'h3FFFF, 16'h1234, 2'b00, 4, 1'b1, 1'b1, 16'h0000};
      vt[7] = '{1'b0, 18'h3FFFF, 16'h0000, 2'b11, 3, 1'b0, 1'b0, 16'h0000};
      vt[8] = '{1'b0, 18'h00010, 16'h0000, 2'b10, 3, 1'b1, 1'b0, 16'hA500};

      // Power-on reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n, sram_doe}), 32'b111110);
      check("rst_addr", 32'(sram_a), 32'd0);
      check("rst_wdata", 32'(sram_d), 32'd0);
      check("rst_acks", 32'({ack[1], ack[0]}), 32'd0);
      check("rst_rdata", 32'({rdat[1], rdat[0]}), 32'd0);
      check("rst_state", 32'(dut_state), 32'(IDLE));
      @(posedge clk); #1 rst = 1'b0;

      // Reset asserted while the write strobe is low.
      we[0] = 1'b1; adr[0] = 18'h00777; wdat[0] = 16'h5555; sel[0] = 2'b11; cyc[0] = 1'b1; stb[0] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (we_n !== 1'b0 && n < 10);
      check("midwr_reached", 32'(we_n), 32'd0);
      rst = 1'b1; cyc[0] = 1'b0; stb[0] = 1'b0;
      @(negedge clk);
      check("midwr_strobes", 32'({ce_n, oe_n, we_n, sram_doe}), 32'b1110);
      check("midwr_ack", 32'({ack[1], ack[0]}), 32'd0);
      check("midwr_state", 32'(dut_state), 32'(IDLE));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      settle();

      // Single-master vectors, back to back.
      for (int i = 0; i < 9; i++) begin
         expect_ack(0, vt[i].we, vt[i].rd);
         xfer(0, vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, 1'b0, lat, o);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
         check($sformatf("v%0d_we_lo", i), 32'(o.we_lo), vt[i].we ? 32'd2 : 32'd0);
         check($sformatf("v%0d_oe_lo", i), 32'(o.oe_lo), vt[i].we ? 32'd0 : 32'd2);
         check($sformatf("v%0d_lb_ub", i), 32'({o.lb_n, o.ub_n}), 32'({vt[i].lb_n, vt[i].ub_n}));
         check($sformatf("v%0d_addr", i), 32'(o.a), 32'(vt[i].adr));
         if (vt[i].we) check($sformatf("v%0d_wdata", i), 32'(o.d), 32'(vt[i].dat));
      end
      check("m1_dat_hold", 32'(rdat[1]), 32'd0);
      settle();

      // Preload for the two-master phases; master 1 writes last so master 0 wins the next tie.
      for (int i = 0; i < 4; i++) begin
         expect_ack(0, 1'b1, 16'h0000);
         xfer(0, 1'b1, 18'h00100 + 18'(i), 16'h1000 + 16'(i), 2'b11, 1'b0, lat, o);
      end
      for (int i = 0; i < 4; i++) begin
         expect_ack(1, 1'b1, 16'h0000);
         xfer(1, 1'b1, 18'h00200 + 18'(i), 16'h2000 + 16'(i), 2'b11, 1'b0, lat, o);
         check($sformatf("m1_wr%0d_latency", i), 32'(lat), 32'd4);
      end
      settle();

      // Both masters contend for four reads each: grants alternate.
`ifdef SRAM_CYC_LOCK_EN
      gap = 1'b1;
`else
      gap = 1'b0;
`endif
      for (int i = 0; i < 4; i++) begin
         expect_ack(0, 1'b0, 16'h1000 + 16'(i));
         expect_ack(1, 1'b0, 16'h2000 + 16'(i));
      end
      fork
         run_reads(0, 18'h00100, 4, !gap, gap);
         run_reads(1, 18'h00200, 4, !gap, gap);
      join
      settle();

      // Master 0 keeps cyc through three transactions while master 1 waits.
`ifdef SRAM_CYC_LOCK_EN
      expect_ack(0, 1'b0, 16'h1000);
      expect_ack(0, 1'b0, 16'h1001);
      expect_ack(0, 1'b0, 16'h1002);
      expect_ack(1, 1'b0, 16'h2000);
`else
      expect_ack(0, 1'b0, 16'h1000);
      expect_ack(1, 1'b0, 16'h2000);
      expect_ack(0, 1'b0, 16'h1001);
      expect_ack(0, 1'b0, 16'h1002);
`endif
      fork
         run_reads(0, 18'h00100, 3, 1'b1, 1'b0);
         run_reads(1, 18'h00200, 1, 1'b0, 1'b0);
      join
      settle();

      // Master abandons a read mid-access: access completes, no ack.
      we[0] = 1'b0; adr[0] = 18'h12345; sel[0] = 2'b11; cyc[0] = 1'b1; stb[0] = 1'b1;
      @(posedge clk); #1;
      cyc[0] = 1'b0; stb[0] = 1'b0;
      n = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (!oe_n) n++;
      end
      check("abort_oe_lo", 32'(n), 32'd2);
      check("abort_state", 32'(dut_state), 32'(IDLE));

      // Address changed during the access must not reach the SRAM.
      expect_ack(0, 1'b0, 16'hBEAA);
      we[0] = 1'b0; adr[0] = 18'h12345; sel[0] = 2'b11; cyc[0] = 1'b1; stb[0] = 1'b1;
      @(posedge clk); #1;
      adr[0] = 18'h00010;
      wait_ack(0, lat, o);
      check("adr_latched", 32'(o.a), 32'h12345);
      @(posedge clk); #1;
      cyc[0] = 1'b0; stb[0] = 1'b0;
      check("m1_dat_hold2", 32'(rdat[1]), 32'h2000);

      repeat (5) @(posedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
